capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Controller that sequences one ADC waveform acquisition end to end. It arms on command and detects a rising threshold crossing on the ADC sample stream (or a forced trigger). It then issues the single-cycle trigger pulse that starts the waveform buffer's DEPTH-sample capture and waits out the capture. Finally it reads the captured samples back through the buffer's read port and streams them as framed bytes to the UART transmitter. It sits between the ADC front end, the waveform buffer and the UART TX.

## Interface
- SAMPLE_W, 14, ADC sample width (≤ 16)
- DEPTH, 500, samples per waveform; must match the buffer
- ADDR_W, 9, buffer address width, ceil(log2(DEPTH))
- HEADER, 8'hFF, frame start byte
- clk  in  1  system clock, ADC sample rate
- reset  in  1  synchronous, active-high
- arm  in  1  pulse; IDLE→ARMED
- force_trig  in  1  pulse; immediate trigger while ARMED
- signal  in  SAMPLE_W  ADC sample, new value every cycle
- trig_level  in  SAMPLE_W  unsigned threshold
- trig_out  out  1  one-cycle pulse to the waveform buffer trigger input
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  SAMPLE_W  buffer read data, valid 1 cycle after rd_addr
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART accepts byte
- armed  out  1  high in ARMED
- busy  out  1  high in CAPTURE through SEND_LO
- done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, ARMED, CAPTURE, HEADER, FETCH, SEND_HI, SEND_LO, DONE.
- IDLE: wait for arm.
- ARMED:
  - prev_sample is registered every cycle.
  - Crossing = prev_sample < trig_level && signal ≥ trig_level, unsigned.
  - Comparison is suppressed in the first ARMED cycle because prev_sample is not yet valid.
  - Crossing or force_trig → register trig_out=1 for one cycle and go to CAPTURE.
- CAPTURE: cap_cnt counts 0..DEPTH-1, one per cycle, starting the cycle trig_out is high. At DEPTH-1, go to HEADER.
- HEADER: tx_data=HEADER, tx_valid=1. On tx_ready, set idx=0 and go to FETCH.
- FETCH:
  - Drive rd_addr=idx for one cycle (tx_valid=0), then go to SEND_HI.
  - Latch rd_data into a sample register on entry to SEND_HI.
- SEND_HI: tx_data={zero pad, sample[SAMPLE_W-1:8]}. Upper bits are zero, so the byte is never 0xFF. On tx_ready, go to SEND_LO.
- SEND_LO: tx_data=sample[7:0]. On tx_ready:
  - if idx==DEPTH-1, go to DONE;
  - else idx+1 and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE (see Configuration).
- Frame = 1 + 2·DEPTH bytes (1001 by default).
- Ignored inputs:
  - arm outside IDLE;
  - force_trig outside ARMED;
  - trig_level changes outside ARMED (sampled live only in ARMED).
- Simultaneous crossing and force_trig: a single trigger.
- idx and cap_cnt never exceed DEPTH-1; no wrap into a second frame.

## Timing
- Reset values: state=IDLE; trig_out, tx_valid, armed, busy, done = 0; rd_addr, tx_data = 0; counters and prev_sample = 0.
- Reset mid-operation: next cycle IDLE with reset values; the partial frame is abandoned and no done pulse is issued.
- Reset wins over arm and force_trig in the same cycle.
- Trigger latency: crossing sample at cycle n → trig_out high at cycle n+1.
- Capture window: DEPTH cycles starting with trig_out; first HEADER byte offered at cycle n+1+DEPTH.
- tx handshake:
  - byte transfers on tx_valid && tx_ready;
  - tx_data is held stable while tx_valid && !tx_ready;
  - tx_valid never drops without a transfer except on reset.
- With tx_ready tied high: 3 cycles per sample (FETCH, SEND_HI, SEND_LO).
- All outputs are registered.

## Configuration
- Macro: CAPTURE_SEQUENCER_AUTO_REARM_EN.
- Defined: DONE → ARMED directly; continuous acquisition with no arm pulse needed. prev_sample validity rule still applies on re-entry.
- Undefined: DONE → IDLE; each frame requires an arm pulse.

## Structure
- Shared package capture_pkg:
  - state enum cap_state_t;
  - default SAMPLE_W, DEPTH and HEADER constants, shared with the waveform buffer and the UART framing.
- One sub-module, threshold_detector: prev_sample register, crossing compare, first-cycle suppression. Output is a crossing pulse.
- The FSM, counters and TX mux stay in capture_sequencer.

## Test plan
- Threshold crossing:
  - Stimulus: arm, trig_level=1000; signal ramps 990,995,1000; tx_ready=1.
  - Required: trig_out one cycle after the 1000 sample; HEADER 8'hFF at trig+DEPTH; 1001 bytes total; done pulse once.
- Back-pressure:
  - Stimulus: tx_ready toggles 1-of-3 cycles; buffer model returns rd_data=addr.
  - Required: bytes {00,00},{00,01}…{01,F3}, stable while stalled, no drops or duplicates.
- No false trigger:
  - Stimulus: signal constant 2000 ≥ trig_level=1000 at arm.
  - Required: no trig_out (first-cycle suppression, no crossing); force_trig → trig_out next cycle.
- Ignored commands:
  - Stimulus: arm and force_trig pulsed during CAPTURE and SEND_HI.
  - Required: no state change and no extra trig_out.
- Reset mid-readout:
  - Stimulus: reset asserted during SEND_LO at idx=200.
  - Required: next cycle tx_valid=0, busy=0, state IDLE, no done; a new arm yields a complete 1001-byte frame.
- Re-arm, with and without CAPTURE_SEQUENCER_AUTO_REARM_EN:
  - Defined: armed=1 the cycle after done.
  - Undefined: armed=0 after done until arm.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the ADC capture path.
// Also used by the waveform buffer and the UART framing.
package capture_pkg;

    localparam int         CAP_SAMPLE_W = 14;
    localparam int         CAP_DEPTH    = 500;
    localparam int         CAP_ADDR_W   = $clog2(CAP_DEPTH);
    localparam logic [7:0] CAP_HEADER   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HEADER  = 3'd3,
        ST_FETCH   = 3'd4,
        ST_SEND_HI = 3'd5,
        ST_SEND_LO = 3'd6,
        ST_DONE    = 3'd7
    } cap_state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// Buffer read port and UART TX byte stream seen by capture_sequencer.
// master = sequencer side, slave = buffer/UART side.
interface capture_sequencer_if
    import capture_pkg::*;
#(
    parameter int SAMPLE_W = CAP_SAMPLE_W,
    parameter int ADDR_W   = CAP_ADDR_W
);

    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;

    modport master (
        output tx_data, tx_valid, rd_addr,
        input  tx_ready, rd_data
    );

    modport slave (
        input  tx_data, tx_valid, rd_addr,
        output tx_ready, rd_data
    );

endinterface

// File: rtl/threshold_detector.sv
// Rising-edge threshold crossing detector for the ADC sample stream.
// The compare is masked on the first enabled cycle, when prev_sample predates arming.
module threshold_detector
    import capture_pkg::*;
#(
    parameter int SAMPLE_W = CAP_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] signal,
    input  logic [SAMPLE_W-1:0] trig_level,
    output logic                crossing
);

    logic [SAMPLE_W-1:0] prev_sample;
    logic                prev_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else begin
            prev_sample <= signal;
            prev_valid  <= enable;
        end
    end

    assign crossing = enable && prev_valid &&
                      (prev_sample < trig_level) && (signal >= trig_level);

endmodule

// File: rtl/capture_sequencer.sv
// Arms, triggers, waits out a DEPTH-sample capture, then streams the buffer as framed bytes.
// Optional build macro CAPTURE_SEQUENCER_AUTO_REARM_EN: DONE returns to ARMED instead of IDLE.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int         SAMPLE_W = CAP_SAMPLE_W,
    parameter int         DEPTH    = CAP_DEPTH,
    parameter int         ADDR_W   = CAP_ADDR_W,
    parameter logic [7:0] HEADER   = CAP_HEADER
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                force_trig,
    input  logic [SAMPLE_W-1:0] signal,
    input  logic [SAMPLE_W-1:0] trig_level,
    output logic                trig_out,
    output logic                armed,
    output logic                busy,
    output logic                done,
    capture_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_ARMED   = 3'(ST_ARMED);
    localparam logic [2:0] S_CAPTURE = 3'(ST_CAPTURE);
    localparam logic [2:0] S_HEADER  = 3'(ST_HEADER);
    localparam logic [2:0] S_FETCH   = 3'(ST_FETCH);
    localparam logic [2:0] S_SEND_HI = 3'(ST_SEND_HI);
    localparam logic [2:0] S_SEND_LO = 3'(ST_SEND_LO);
    localparam logic [2:0] S_DONE    = 3'(ST_DONE);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] cap_cnt;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        sample_lo;
    logic [15:0]       rd_ext;
    logic              crossing;
    logic              tx_fire;

    assign tx_fire = bus.tx_valid && bus.tx_ready;
    assign rd_ext  = 16'(bus.rd_data);

    threshold_detector #(.SAMPLE_W(SAMPLE_W)) u_detect (
        .clk        (clk),
        .reset      (reset),
        .enable     (state == S_ARMED),
        .signal     (signal),
        .trig_level (trig_level),
        .crossing   (crossing)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (arm) state_next = S_ARMED;
            S_ARMED:   if (crossing || force_trig) state_next = S_CAPTURE;
            S_CAPTURE: if (cap_cnt == LAST) state_next = S_HEADER;
            S_HEADER:  if (tx_fire) state_next = S_FETCH;
            S_FETCH:   state_next = S_SEND_HI;
            S_SEND_HI: if (tx_fire) state_next = S_SEND_LO;
            S_SEND_LO: if (tx_fire) state_next = (idx == LAST) ? S_DONE : S_FETCH;
`ifdef CAPTURE_SEQUENCER_AUTO_REARM_EN
            S_DONE:    state_next = S_ARMED;
`else
            S_DONE:    state_next = S_IDLE;
`endif
            default:   state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from state_next so they line up with the new state.
    // rd_addr runs one cycle ahead of FETCH so rd_data is already valid when FETCH latches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            trig_out     <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cap_cnt      <= '0;
            idx          <= '0;
            sample_lo    <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.rd_addr  <= '0;
        end else begin
            state        <= state_next;
            trig_out     <= (state == S_ARMED) && (state_next == S_CAPTURE);
            armed        <= (state_next == S_ARMED);
            busy         <= state_next inside {S_CAPTURE, S_HEADER, S_FETCH, S_SEND_HI, S_SEND_LO};
            done         <= (state_next == S_DONE);
            bus.tx_valid <= state_next inside {S_HEADER, S_SEND_HI, S_SEND_LO};

            case (state)
                S_ARMED: cap_cnt <= '0;
                S_CAPTURE: begin
                    if (cap_cnt != LAST) cap_cnt <= cap_cnt + ADDR_W'(1);
                    if (state_next == S_HEADER) begin
                        bus.tx_data <= HEADER;
                        bus.rd_addr <= '0;
                    end
                end
                S_HEADER: if (tx_fire) idx <= '0;
                S_FETCH: begin
                    sample_lo   <= rd_ext[7:0];
                    bus.tx_data <= rd_ext[15:8];
                end
                S_SEND_HI: if (tx_fire) begin
                    bus.tx_data <= sample_lo;
                    if (idx != LAST) bus.rd_addr <= idx + ADDR_W'(1);
                end
                S_SEND_LO: if (tx_fire && idx != LAST) idx <= idx + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: crossing, back-pressure, false trigger, ignored commands,
// reset mid-readout and re-arm behaviour (CAPTURE_SEQUENCER_AUTO_REARM_EN aware).
module tb_capture_sequencer;

    localparam int         DEPTH     = 500;
    localparam int         FRAME_LEN = 1 + 2 * DEPTH;
    localparam logic [7:0] HEADER_B  = 8'hFF;
`ifdef CAPTURE_SEQUENCER_AUTO_REARM_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        force_trig;
    logic [13:0] signal;
    logic [13:0] trig_level;
    logic        trig_out;
    logic        armed;
    logic        busy;
    logic        done;

    capture_sequencer_if #(.SAMPLE_W(14), .ADDR_W(9)) bus ();

    capture_sequencer #(.SAMPLE_W(14), .DEPTH(DEPTH), .ADDR_W(9), .HEADER(HEADER_B)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .force_trig (force_trig),
        .signal     (signal),
        .trig_level (trig_level),
        .trig_out   (trig_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous read returning the address as data.
    always @(posedge clk) bus.rd_data <= 14'(bus.rd_addr);

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    int         trig_cnt = 0;
    int         done_cnt = 0;
    int         trig_cyc = 0;
    int         first_valid_cyc = -1;
    logic       stall_prev = 1'b0;
    logic [7:0] held_data = '0;
    logic [7:0] q[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic f, input logic [13:0] s);
        arm        = a;
        force_trig = f;
        signal     = s;
        step();
    endtask

    task automatic clearLog();
        q.delete();
        trig_cnt        = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clearLog();
    endtask

    task automatic waitDone(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, done_cnt - start, 1);
    endtask

    task automatic waitBytes(input string tag, input int count, input int budget);
        int n;
        n = 0;
        while (q.size() < count && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, q.size(), count);
    endtask

    task automatic checkFrame(input string tag);
        int         bad;
        int         first_bad;
        logic [7:0] exp_b;
        bad       = 0;
        first_bad = -1;
        checkOutput({tag, "_len"}, q.size(), FRAME_LEN);
        for (int i = 0; i < q.size() && i < FRAME_LEN; i++) begin
            if (i == 0)          exp_b = HEADER_B;
            else if (i % 2 == 1) exp_b = 8'(((i - 1) / 2) >> 8);
            else                 exp_b = 8'(((i - 2) / 2) & 255);
            if (q[i] !== exp_b) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checkOutput({tag, "_bad_bytes"}, bad, 0);
        if (bad != 0) $display("[TB] %s first wrong byte at index %0d", tag, first_bad);
    endtask

    // Byte logger and tx_ready driver; a byte is logged at the negedge before the edge that transfers it.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_prev && !reset) begin
                checkOutput("hold_valid", bus.tx_valid, 1);
                checkOutput("hold_data", bus.tx_data, held_data);
            end
            bus.tx_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (trig_out) begin
                trig_cnt++;
                trig_cyc = cyc;
            end
            if (done) done_cnt++;
            if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.tx_valid && bus.tx_ready && !reset) q.push_back(bus.tx_data);
            stall_prev = bus.tx_valid && !bus.tx_ready;
            held_data  = bus.tx_data;
        end
    end

    initial begin
        reset      = 1'b1;
        arm        = 1'b0;
        force_trig = 1'b0;
        signal     = '0;
        trig_level = '0;
        step();
        step();
        checkOutput("rst_trig_out", trig_out, 0);
        checkOutput("rst_armed", armed, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tx_valid", bus.tx_valid, 0);
        checkOutput("rst_tx_data", bus.tx_data, 0);
        checkOutput("rst_rd_addr", bus.rd_addr, 0);
        reset = 1'b0;
        clearLog();

        $display("[TB] threshold crossing");
        trig_level = 14'd1000;
        applyStimulus(1'b1, 1'b0, 14'd990);
        checkOutput("t1_armed", armed, 1);
        applyStimulus(1'b0, 1'b0, 14'd995);
        checkOutput("t1_no_early_trig", trig_out, 0);
        applyStimulus(1'b0, 1'b0, 14'd1000);
        checkOutput("t1_trig", trig_out, 1);
        checkOutput("t1_busy", busy, 1);
        step();
        checkOutput("t1_trig_single", trig_out, 0);
        waitDone("t1_done_seen", 4000);
        step();
        checkOutput("t1_rearm", armed, AUTO);
        checkFrame("t1");
        checkOutput("t1_header_latency", first_valid_cyc - trig_cyc, DEPTH);
        checkOutput("t1_trig_cnt", trig_cnt, 1);
        repeat (5) step();
        checkOutput("t1_armed_later", armed, AUTO);
        checkOutput("t1_done_cnt", done_cnt, 1);

        $display("[TB] back-pressure");
        doReset();
        ready_mode = 1;
        applyStimulus(1'b1, 1'b0, 14'd0);
        applyStimulus(1'b0, 1'b1, 14'd0);
        force_trig = 1'b0;
        checkOutput("t2_force_trig", trig_out, 1);
        waitDone("t2_done_seen", 8000);
        checkFrame("t2");
        checkOutput("t2_trig_cnt", trig_cnt, 1);

        $display("[TB] no false trigger and ignored commands");
        doReset();
        ready_mode = 0;
        trig_level = 14'd1000;
        applyStimulus(1'b1, 1'b0, 14'd2000);
        arm = 1'b0;
        repeat (10) step();
        checkOutput("t3_no_false_trig", trig_cnt, 0);
        checkOutput("t3_armed", armed, 1);
        applyStimulus(1'b0, 1'b1, 14'd2000);
        force_trig = 1'b0;
        checkOutput("t3_force_trig", trig_out, 1);
        repeat (5) applyStimulus(1'b1, 1'b1, 14'd2000);
        applyStimulus(1'b0, 1'b0, 14'd2000);
        checkOutput("t3_busy_capture", busy, 1);
        checkOutput("t3_armed_capture", armed, 0);
        checkOutput("t3_trig_capture", trig_cnt, 1);
        waitBytes("t3_reach_readout", 2, 1000);
        repeat (60) applyStimulus(1'b1, 1'b1, 14'd2000);
        applyStimulus(1'b0, 1'b0, 14'd2000);
        checkOutput("t3_busy_readout", busy, 1);
        waitDone("t3_done_seen", 4000);
        checkFrame("t3");
        checkOutput("t3_trig_cnt", trig_cnt, 1);

        $display("[TB] reset mid-readout");
        doReset();
        signal = 14'd0;
        applyStimulus(1'b1, 1'b0, 14'd0);
        applyStimulus(1'b0, 1'b1, 14'd0);
        force_trig = 1'b0;
        waitBytes("t4_reach_idx200", 403, 2000);
        checkOutput("t4_lo_byte_200", bus.tx_data, 8'hC8);
        checkOutput("t4_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t4_tx_valid", bus.tx_valid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_armed", armed, 0);
        step();
        step();
        checkOutput("t4_no_done", done_cnt, 0);
        checkOutput("t4_idle_tx_valid", bus.tx_valid, 0);
        clearLog();
        applyStimulus(1'b1, 1'b0, 14'd0);
        applyStimulus(1'b0, 1'b1, 14'd0);
        force_trig = 1'b0;
        waitDone("t4_done_seen", 4000);
        step();
        checkOutput("t4_rearm", armed, AUTO);
        checkFrame("t4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
